// File: rtl/ram128_pkg.sv
// Shared constants and FSM state type for the RAM128 Wishbone controller.
package ram128_pkg;

  localparam int unsigned AW_DEF    = 7;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned RAM_WORDS = 128;

  localparam logic [31:0] CLR_VALUE_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_ACK     = 2'd3
  } state_e;

endpackage

// File: rtl/ram128_clr_seq.sv
// Word-address counter for the post-reset clear sweep; done_c flags the last word.
module ram128_clr_seq
  import ram128_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  output logic [AW-1:0] cnt_o,
  output logic          done_c
);

  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (run_i) cnt_d = cnt_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign done_c = run_i && (cnt_q == AW'(RAM_WORDS - 1));

endmodule

// File: rtl/ram128_wb_ctrl.sv
// Wishbone-classic slave driving one RAM128 port with registered ack/read data.
// Optional post-reset clear sweep is enabled by defining RAM128_WB_CTRL_CLR_EN.
module ram128_wb_ctrl
  import ram128_pkg::*;
#(
  parameter int unsigned   AW        = AW_DEF,
  parameter int unsigned   DW        = DW_DEF,
  parameter logic [DW-1:0] CLR_VALUE = DW'(CLR_VALUE_DEF)
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [SEL_W-1:0] wb_sel_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [DW-1:0]    wb_dat_i,
  output logic [DW-1:0]    wb_dat_o,
  output logic             wb_ack_o,
  output logic             busy_o,
  output logic             ram_en0,
  output logic [SEL_W-1:0] ram_we0,
  output logic [AW-1:0]    ram_a0,
  output logic [DW-1:0]    ram_di0,
  input  logic [DW-1:0]    ram_do0
);

  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic             req_c;
  logic             en_c;
  logic [SEL_W-1:0] we_c;
  logic [AW-1:0]    a_c;
  logic [DW-1:0]    di_c;
  logic             unused_c;

  assign req_c = wb_cyc_i & wb_stb_i;

`ifdef RAM128_WB_CTRL_CLR_EN
  localparam state_e RST_STATE = ST_CLEAR;

  logic [AW-1:0] clr_cnt;
  logic          clr_run_c;
  logic          clr_done_c;

  assign clr_run_c = (state_q == ST_CLEAR);

  ram128_clr_seq #(.AW(AW)) u_clr_seq (
    .clk    (CLK),
    .rst_n  (RESETn),
    .run_i  (clr_run_c),
    .cnt_o  (clr_cnt),
    .done_c (clr_done_c)
  );

  assign busy_o   = clr_run_c;
  assign unused_c = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};
`else
  localparam state_e RST_STATE = ST_IDLE;

  assign busy_o   = 1'b0;
  assign unused_c = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0], CLR_VALUE};
`endif

  // Next state, registered ack/data and the same-cycle RAM strobe.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    en_c    = 1'b0;
    we_c    = '0;
    a_c     = '0;
    di_c    = '0;
    unique case (state_q)
`ifdef RAM128_WB_CTRL_CLR_EN
      ST_CLEAR: begin
        en_c = 1'b1;
        we_c = '1;
        a_c  = clr_cnt;
        di_c = CLR_VALUE;
        if (clr_done_c) state_d = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        if (req_c) begin
          en_c    = 1'b1;
          a_c     = wb_adr_i[AW+1:2];
          di_c    = wb_dat_i;
          we_c    = wb_we_i ? wb_sel_i : '0;
          ack_d   = wb_we_i;
          state_d = wb_we_i ? ST_ACK : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        dat_d   = ram_do0;
        ack_d   = wb_cyc_i;
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= RST_STATE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  // RAM pins are quiet while reset is held, whatever the state register says.
  assign ram_en0  = RESETn & en_c;
  assign ram_we0  = RESETn ? we_c : '0;
  assign ram_a0   = RESETn ? a_c  : '0;
  assign ram_di0  = RESETn ? di_c : '0;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_ram128_wb_ctrl.sv
// Directed bench for ram128_wb_ctrl with a transaction-timing model and a RAM128 behavioural model.
module tb_ram128_wb_ctrl;

`ifdef RAM128_WB_CTRL_CLR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  localparam logic [31:0] CLR_V = 32'hA5A5_A5A5;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_ack_o, busy_o, ram_en0;
  logic [3:0]  ram_we0;
  logic [6:0]  ram_a0;
  logic [31:0] ram_di0, ram_do0;

  int n_chk  = 0;
  int n_pass = 0;
  int busy_cnt = 0;

  ram128_wb_ctrl #(.AW(7), .DW(32), .CLR_VALUE(CLR_V)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .busy_o(busy_o),
    .ram_en0(ram_en0), .ram_we0(ram_we0), .ram_a0(ram_a0),
    .ram_di0(ram_di0), .ram_do0(ram_do0)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // RAM128 macro: samples strobes on the edge, Do0 holds until the next enabled access.
  logic [31:0] ram_mem [128];
  initial begin
    for (int i = 0; i < 128; i++) ram_mem[i] = 32'h0;
    ram_do0 = 32'h0;
  end
  always @(posedge CLK) begin : ram_b
    logic [31:0] w;
    if (ram_en0) begin
      w = ram_mem[ram_a0];
      for (int b = 0; b < 4; b++) if (ram_we0[b]) w[8*b +: 8] = ram_di0[8*b +: 8];
      ram_mem[ram_a0] <= w;
      ram_do0         <= w;
    end
  end

  always @(negedge CLK) if (busy_o) busy_cnt++;

  // Timing model: accept at the first free cycle, write ack +1, read ack/data +2.
  logic [31:0] m_mem [128];
  int          m_k = 0, m_k0 = 0, m_clr_end = 0, m_ready = 0;
  int          m_wr_ack = -10, m_rd_k = -10, m_rd_ack = -10;
  bit          m_in_rst = 1'b1, m_rd_cyc = 1'b0;
  logic [31:0] m_rd_val = 32'h0, m_dat = 32'h0;
  initial for (int i = 0; i < 128; i++) m_mem[i] = 32'h0;

  always @(negedge CLK) begin : mdl_b
    logic        e_en, e_ack, e_busy;
    logic [3:0]  e_we;
    logic [6:0]  e_a;
    logic [31:0] e_di, w;
    e_en = 1'b0; e_we = 4'h0; e_a = 7'h0; e_di = 32'h0;
    if (!RESETn) begin
      m_in_rst = 1'b1; m_wr_ack = -10; m_rd_ack = -10; m_dat = 32'h0;
      chk("rst_ack",  32'(wb_ack_o), 32'h0);
      chk("rst_dat",  wb_dat_o,      32'h0);
      chk("rst_busy", 32'(busy_o),   32'(CLR));
      chk("rst_en",   32'(ram_en0),  32'h0);
      chk("rst_we",   32'(ram_we0),  32'h0);
      chk("rst_a0",   32'(ram_a0),   32'h0);
      chk("rst_di",   ram_di0,       32'h0);
    end else begin
      if (m_in_rst) begin
        m_in_rst  = 1'b0;
        m_k0      = m_k;
        m_clr_end = m_k + (CLR ? 128 : 0);
        m_ready   = m_clr_end;
      end
      if (m_k == m_rd_k + 1) m_rd_cyc = wb_cyc_i;
      if (m_k == m_rd_ack) m_dat = m_rd_val;
      e_ack  = (m_k == m_wr_ack) || (m_k == m_rd_ack && m_rd_cyc);
      e_busy = (m_k < m_clr_end);
      if (m_k < m_clr_end) begin
        e_en = 1'b1; e_we = 4'hF; e_a = 7'(m_k - m_k0); e_di = CLR_V;
        m_mem[e_a] = CLR_V;
      end else if (m_k >= m_ready && wb_cyc_i && wb_stb_i) begin
        e_en = 1'b1; e_a = wb_adr_i[8:2]; e_di = wb_dat_i;
        if (wb_we_i) begin
          e_we = wb_sel_i;
          w = m_mem[e_a];
          for (int b = 0; b < 4; b++) if (wb_sel_i[b]) w[8*b +: 8] = wb_dat_i[8*b +: 8];
          m_mem[e_a] = w;
          m_wr_ack = m_k + 1;
          m_ready  = m_k + 2;
        end else begin
          m_rd_k   = m_k;
          m_rd_ack = m_k + 2;
          m_rd_val = m_mem[e_a];
          m_ready  = m_k + 3;
        end
      end
      chk("ack",  32'(wb_ack_o), 32'(e_ack));
      chk("dat",  wb_dat_o,      m_dat);
      chk("busy", 32'(busy_o),   32'(e_busy));
      chk("en",   32'(ram_en0),  32'(e_en));
      chk("we",   32'(ram_we0),  32'(e_we));
      if (e_en) begin
        chk("a0", 32'(ram_a0), 32'(e_a));
        chk("di", ram_di0,     e_di);
      end
    end
    m_k++;
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // One bus transfer starting in the current cycle; returns latency-checked read data.
  task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int exp_lat,
                      output logic [31:0] rdat, output logic [6:0] a_seen,
                      output logic [3:0] we_seen);
    int lat;
    bit got;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    lat = 0; got = 1'b0; rdat = 32'h0; a_seen = 7'h0; we_seen = 4'h0;
    while (!got && lat < 400) begin
      @(negedge CLK);
      if (lat == 0) begin a_seen = ram_a0; we_seen = ram_we0; end
      if (wb_ack_o) begin got = 1'b1; rdat = wb_dat_o; end
      else lat++;
    end
    chk("ack_seen", 32'(got), 32'h1);
    if (got) chk("latency", 32'(lat), 32'(exp_lat));
    step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [6:0]  a_s;
    logic [3:0]  we_s;
    int          n_ack, n_en, ack_i0, ack_i1;

    RESETn = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 4'h0; wb_adr_i = 32'h0; wb_dat_i = 32'h0;
    repeat (3) step();

    // Request during the sweep: stalled until busy_o falls, then word 127 reads back.
    RESETn = 1'b1; busy_cnt = 0;
    xfer(1'b0, 32'h0000_01FC, 4'h0, 32'h0, CLR ? 130 : 2, rd, a_s, we_s);
    chk("sweep_busy_cycles", 32'(busy_cnt), CLR ? 32'd128 : 32'd0);
    chk("sweep_rd127", rd, CLR ? 32'hA5A5_A5A5 : 32'h0);

    xfer(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1, rd, a_s, we_s);
    chk("wr_a0", 32'(a_s), 32'd4);
    chk("wr_we", 32'(we_s), 32'hF);
    xfer(1'b0, 32'h0000_0010, 4'h0, 32'h0, 2, rd, a_s, we_s);
    chk("rd_deadbeef", rd, 32'hDEAD_BEEF);

    xfer(1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1, rd, a_s, we_s);
    xfer(1'b1, 32'h0000_0020, 4'b0010, 32'h0000_AB00, 1, rd, a_s, we_s);
    xfer(1'b0, 32'h0000_0020, 4'h0, 32'h0, 2, rd, a_s, we_s);
    chk("rd_byte_merge", rd, 32'h1122_AB44);

    xfer(1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 1, rd, a_s, we_s);
    chk("sel0_we", 32'(we_s), 32'h0);
    xfer(1'b0, 32'h0000_0010, 4'h0, 32'h0, 2, rd, a_s, we_s);
    chk("rd_after_sel0", rd, 32'hDEAD_BEEF);

    xfer(1'b1, 32'hFFFF_FE04, 4'hF, 32'hCAFE_F00D, 1, rd, a_s, we_s);
    chk("upper_bits_a0", 32'(a_s), 32'd1);
    xfer(1'b0, 32'h0000_0004, 4'h0, 32'h0, 2, rd, a_s, we_s);
    chk("rd_upper_alias", rd, 32'hCAFE_F00D);

    // Strobe held across two reads: one ack and one RAM strobe per request.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0020;
    n_ack = 0; n_en = 0; ack_i0 = -1; ack_i1 = -1;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      if (wb_ack_o) begin
        if (n_ack == 0) ack_i0 = i; else ack_i1 = i;
        n_ack++;
      end
      if (ram_en0) n_en++;
      step();
      if (i == 5) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
    end
    chk("b2b_acks", 32'(n_ack), 32'd2);
    chk("b2b_strobes", 32'(n_en), 32'd2);
    chk("b2b_first_ack", 32'(ack_i0), 32'd2);
    chk("b2b_spacing", 32'(ack_i1 - ack_i0), 32'd3);

    // Abort in RD_WAIT: no ack, then a normal write.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0010;
    step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (wb_ack_o) n_ack++;
    end
    chk("abort_no_ack", 32'(n_ack), 32'd0);
    step();
    xfer(1'b1, 32'h0000_0030, 4'hF, 32'h0BAD_CAFE, 1, rd, a_s, we_s);

    // Reset while a read waits on RAM data.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0004;
    step();
    RESETn = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    #1;
    chk("midrst_ack", 32'(wb_ack_o), 32'h0);
    chk("midrst_dat", wb_dat_o, 32'h0);
    chk("midrst_en", 32'(ram_en0), 32'h0);
    repeat (2) step();
    RESETn = 1'b1;
    @(negedge CLK);
    chk("restart_en", 32'(ram_en0), 32'(CLR));
    chk("restart_a0", 32'(ram_a0), 32'h0);
    step();
    xfer(1'b0, 32'h0000_0004, 4'h0, 32'h0, CLR ? 129 : 2, rd, a_s, we_s);
    chk("rd_after_restart", rd, CLR ? 32'hA5A5_A5A5 : 32'hCAFE_F00D);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
